// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache feeding the IF stage.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_fetch #(
  parameter int          INDEX_BITS = 7,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        if_stall_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_inst_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag_in;
  logic [INDEX_BITS-1:0]  fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   hit;
  logic                   fetch_start;
  logic                   fill;
  logic                   fwd;
  logic                   unused_pc_bits;

  assign idx            = if_pc_i[INDEX_BITS+1:2];
  assign tag_in         = if_pc_i[31:INDEX_BITS+2];
  assign fill_idx       = mem_addr_o[INDEX_BITS+1:2];
  assign fill_tag       = mem_addr_o[31:INDEX_BITS+2];
  assign unused_pc_bits = ^if_pc_i[1:0];

  assign hit         = if_req_i && valid_q[idx] && (tag_q[idx] == tag_in);
  assign fetch_start = (state == S_IDLE) && if_req_i && !flush_i && !hit;
  assign fill        = (state != S_IDLE) && mem_done_i;
  // The fetched word goes straight to IF when the pc still matches the miss
  assign fwd         = (state == S_WAIT) && mem_done_i && !flush_i && if_req_i &&
                       (if_pc_i[31:2] == mem_addr_o[31:2]);

  always_comb begin
    inst_o         = 32'h0;
    inst_valid_o   = 1'b0;
    if_stall_req_o = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (if_req_i && !flush_i) begin
            if (hit) begin
              inst_o       = data_q[idx];
              inst_valid_o = 1'b1;
            end else begin
              if_stall_req_o = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (fwd) begin
            inst_o       = mem_inst_i;
            inst_valid_o = 1'b1;
          end else begin
            if_stall_req_o = 1'b1;
          end
        end
        default: if_stall_req_o = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= RESET_PC;
    end else if (rdy) begin
      unique case (state)
        S_IDLE: begin
          if (fetch_start) begin
            mem_addr_o <= {if_pc_i[31:2], 2'b00};
            mem_req_o  <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done_i) begin
            valid_q[fill_idx] <= 1'b1;
            mem_req_o         <= 1'b0;
            mem_addr_o        <= RESET_PC;
            state             <= S_IDLE;
          end else if (flush_i) begin
            state <= S_DISCARD;
          end
        end
        default: begin
          // The memory transaction cannot be cancelled, so wait it out and keep the line
          if (mem_done_i) begin
            valid_q[fill_idx] <= 1'b1;
            mem_req_o         <= 1'b0;
            mem_addr_o        <= RESET_PC;
            state             <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst_i;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
    end else if (rdy) begin
      if ((state == S_IDLE) && hit && !flush_i) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (fetch_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus a randomized
// access stream compared against an address-keyed cache model.
module tb_icache_fetch;

  localparam int          INDEX_BITS = 7;
  localparam int          LINES      = 1 << INDEX_BITS;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req_i, flush_i, mem_done_i;
  logic [31:0] if_pc_i, mem_inst_i;
  logic [31:0] inst_o, mem_addr_o;
  logic        inst_valid_o, if_stall_req_o, mem_req_o;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each line remembers the full word address it holds
  bit          m_valid [LINES];
  logic [29:0] m_addr  [LINES];
  logic [31:0] m_data  [LINES];

  icache_fetch #(.INDEX_BITS(INDEX_BITS), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_req_i(if_req_i), .if_pc_i(if_pc_i),
    .flush_i(flush_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .if_stall_req_o(if_stall_req_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_done_i(mem_done_i), .mem_inst_i(mem_inst_i)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endfunction

  function automatic void m_fill(input logic [31:0] pc, input logic [31:0] d);
    int i;
    i = (pc / 4) % LINES;
    m_valid[i] = 1;
    m_addr[i]  = pc[31:2];
    m_data[i]  = d;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = (pc / 4) % LINES;
    return m_valid[i] && (m_addr[i] == pc[31:2]);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] pc);
    return m_data[(pc / 4) % LINES];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return ((pc & 32'hFFFF_FFFC) * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic test_reset();
    rst = 1; rdy = 1; if_req_i = 1; if_pc_i = 32'h0; flush_i = 0;
    mem_done_i = 0; mem_inst_i = 32'h0;
    tick(); #2;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", inst_valid_o); end
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", if_stall_req_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h exp 0", inst_o); end
    tick();
    rst = 0; if_req_i = 0; #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b exp 0", mem_req_o); end
    checks++; if (mem_addr_o !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr got %h exp %h", mem_addr_o, RESET_PC); end
    m_clear();
  endtask

  task automatic test_first_miss();
    if_req_i = 1; if_pc_i = 32'h0; #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_stall got %b exp 1", if_stall_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_valid got %b exp 0", inst_valid_o); end
    tick(); #2;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_req got %b exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL miss_addr got %h exp 0", mem_addr_o); end
    mem_done_i = 1; mem_inst_i = 32'h0000_0513; #2;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL fwd_valid got %b exp 1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0513) begin errors++; $display("[TB] FAIL fwd_inst got %h exp 00000513", inst_o); end
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fwd_stall got %b exp 0", if_stall_req_o); end
    m_fill(32'h0, 32'h0000_0513);
    tick();
    mem_done_i = 0;
  endtask

  task automatic test_hit();
    if_req_i = 1; if_pc_i = 32'h0; #2;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL hit_valid got %b exp 1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0513) begin errors++; $display("[TB] FAIL hit_inst got %h exp 00000513", inst_o); end
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("[TB] FAIL hit_stall got %b exp 0", if_stall_req_o); end
    tick(); #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL hit_no_req got %b exp 0", mem_req_o); end
  endtask

  task automatic test_conflict();
    if_req_i = 1; if_pc_i = 32'h0000_0200; #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL conf_stall got %b exp 1", if_stall_req_o); end
    tick(); #2;
    checks++; if (mem_addr_o !== 32'h0000_0200) begin errors++; $display("[TB] FAIL conf_addr got %h exp 00000200", mem_addr_o); end
    mem_done_i = 1; mem_inst_i = 32'hAAAA_0001; #2;
    checks++; if (inst_o !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL conf_inst got %h exp aaaa0001", inst_o); end
    m_fill(32'h200, 32'hAAAA_0001);
    tick();
    mem_done_i = 0; if_pc_i = 32'h0; #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL conf_evict_stall got %b exp 1", if_stall_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL conf_evict_valid got %b exp 0", inst_valid_o); end
    tick(); #2;
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL conf_refetch_addr got %h exp 0", mem_addr_o); end
    mem_done_i = 1; mem_inst_i = 32'h0000_0513;
    m_fill(32'h0, 32'h0000_0513);
    tick();
    mem_done_i = 0; if_req_i = 0;
  endtask

  task automatic test_flush_discard();
    if_req_i = 1; if_pc_i = 32'h0000_0010; #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fl_stall got %b exp 1", if_stall_req_o); end
    tick();
    flush_i = 1; #2;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid got %b exp 0", inst_valid_o); end
    tick();
    flush_i = 0;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fl_req_held got %b exp 1", mem_req_o); end
      checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fl_discard_stall got %b exp 1", if_stall_req_o); end
      tick();
    end
    mem_done_i = 1; mem_inst_i = 32'h1357_9BDF; #2;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_no_fwd got %b exp 0", inst_valid_o); end
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fl_done_stall got %b exp 1", if_stall_req_o); end
    m_fill(32'h10, 32'h1357_9BDF);
    tick();
    mem_done_i = 0; #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_req_drop got %b exp 0", mem_req_o); end
    checks++; if (inst_o !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL fl_later_hit got %h exp 13579bdf", inst_o); end
    if_pc_i = 32'h0000_0300; flush_i = 1; #2;
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_flush_stall got %b exp 0", if_stall_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_flush_valid got %b exp 0", inst_valid_o); end
    tick();
    flush_i = 0; if_req_i = 0; #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_flush_noreq got %b exp 0", mem_req_o); end
  endtask

  task automatic test_rdy_freeze();
    rdy = 0; if_req_i = 1; if_pc_i = 32'h0000_0048;
    tick();
    if_req_i = 0; #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL frz_idle_req got %b exp 0", mem_req_o); end
    rdy = 1; if_req_i = 1; if_pc_i = 32'h0000_0044;
    tick(); #2;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL frz_req got %b exp 1", mem_req_o); end
    rdy = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL frz_req_held got %b exp 1", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h44) begin errors++; $display("[TB] FAIL frz_addr_held got %h exp 00000044", mem_addr_o); end
    end
    rdy = 1;
    tick(); #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL frz_resume_stall got %b exp 1", if_stall_req_o); end
    mem_done_i = 1; mem_inst_i = 32'h0BAD_CAFE; #2;
    checks++; if (inst_o !== 32'h0BAD_CAFE) begin errors++; $display("[TB] FAIL frz_fwd got %h exp 0badcafe", inst_o); end
    m_fill(32'h44, 32'h0BAD_CAFE);
    tick();
    mem_done_i = 0; if_req_i = 0;
  endtask

  task automatic test_reset_mid_miss();
    if_req_i = 1; if_pc_i = 32'h0000_0080;
    tick(); #2;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL rmm_req got %b exp 1", mem_req_o); end
    rst = 1;
    tick();
    rst = 0; if_req_i = 0; #2;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rmm_req_clear got %b exp 0", mem_req_o); end
    checks++; if (mem_addr_o !== RESET_PC) begin errors++; $display("[TB] FAIL rmm_addr got %h exp %h", mem_addr_o, RESET_PC); end
    mem_done_i = 1; mem_inst_i = 32'hDEAD_BEEF;
    tick();
    mem_done_i = 0;
    m_clear();
    if_req_i = 1; if_pc_i = 32'h0; #2;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL rmm_pc0_miss got %b exp 1", if_stall_req_o); end
    if_pc_i = 32'h0000_0080; #2;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rmm_stray_fill got %b exp 0", inst_valid_o); end
    if_req_i = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc, w;
    int lat, mode;
    for (int n = 0; n < 200; n++) begin
      pc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if_req_i = 1; if_pc_i = pc; #2;
      if (m_hit(pc)) begin
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== m_read(pc)) begin errors++; $display("[TB] FAIL rnd_hit pc %h got %b/%h exp 1/%h", pc, inst_valid_o, inst_o, m_read(pc)); end
        tick();
      end else begin
        checks++; if (if_stall_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_miss pc %h got stall %b valid %b exp 1/0", pc, if_stall_req_o, inst_valid_o); end
        tick(); #2;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== (pc & 32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL rnd_req got %b/%h exp 1/%h", mem_req_o, mem_addr_o, pc & 32'hFFFF_FFFC); end
        lat  = $urandom_range(0, 3);
        mode = $urandom_range(0, 3);
        for (int k = 0; k < lat; k++) begin
          flush_i = (mode == 0) && (k == 0); #2;
          checks++; if (mem_req_o !== 1'b1 || if_stall_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_wait got req %b stall %b valid %b exp 1/1/0", mem_req_o, if_stall_req_o, inst_valid_o); end
          tick();
          flush_i = 0;
        end
        w = mem_word(pc);
        flush_i = (mode == 0) && (lat == 0);
        mem_done_i = 1; mem_inst_i = w; #2;
        if (mode == 0) begin
          checks++; if (inst_valid_o !== 1'b0 || if_stall_req_o !== 1'b1) begin errors++; $display("[TB] FAIL rnd_discard got valid %b stall %b exp 0/1", inst_valid_o, if_stall_req_o); end
        end else begin
          checks++; if (inst_valid_o !== 1'b1 || inst_o !== w || if_stall_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_fwd got %b/%h/%b exp 1/%h/0", inst_valid_o, inst_o, if_stall_req_o, w); end
        end
        m_fill(pc, w);
        tick();
        mem_done_i = 0; flush_i = 0; if_req_i = 0; #2;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_req_drop got %b exp 0", mem_req_o); end
      end
    end
    if_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_hit();
    test_conflict();
    test_flush_discard();
    test_rdy_freeze();
    test_reset_mid_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller. Produces the IF stall request that the stall controller consumes.
- On a hit, returns the instruction combinationally in the same cycle.
- On a miss, holds IF stalled, fetches one 32-bit word through a req/done handshake, fills the line, then releases the stall.

Parameters:
- INDEX_BITS, 7, log2 of line count (128 lines, one 32-bit word each); tag width = 30 - INDEX_BITS.
- RESET_PC, 32'h0, address reported on mem_addr_o while idle and after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- if_req_i  in  1  IF stage requests an instruction this cycle
- if_pc_i  in  32  fetch address; bits [1:0] ignored
- flush_i  in  1  branch redirect; discard any outstanding fetch result
- inst_o  out  32  instruction for IF/ID
- inst_valid_o  out  1  inst_o is valid for if_pc_i this cycle
- if_stall_req_o  out  1  stall request to the stall controller
- mem_req_o  out  1  fetch request to the memory controller
- mem_addr_o  out  32  word-aligned fetch address
- mem_done_i  in  1  one-cycle pulse; mem_inst_i valid
- mem_inst_i  in  32  fetched word

Behaviour:
- Storage:
  - valid[2^INDEX_BITS] as a flop vector.
  - tag and data arrays; index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2].
- Reset (rst=1 at a clk edge):
  - all valid bits cleared; state=IDLE; mem_req_o=0; mem_addr_o=RESET_PC.
  - inst_o=0, inst_valid_o=0, if_stall_req_o=0 while rst is high.
  - Reset mid-miss abandons the fetch; a late mem_done_i after reset is ignored.
- Hit (combinational):
  - Condition: if_req_i & valid[idx] & tag match.
  - inst_o=data[idx], inst_valid_o=1, if_stall_req_o=0 in the same cycle.
- States:
  - IDLE
    - Miss with if_req_i & !flush_i: if_stall_req_o=1 combinationally.
    - Next edge: latch the pc with [1:0]=0 into mem_addr_o, mem_req_o<=1, go to WAIT.
  - WAIT
    - if_stall_req_o=1 and mem_req_o=1; mem_addr_o held stable.
    - On mem_done_i: write tag/data/valid at the latched index; mem_req_o<=0; go to IDLE.
    - In the done cycle, if the cycle is not discarded and if_pc_i equals the latched address: inst_o=mem_inst_i, inst_valid_o=1, if_stall_req_o=0 (forwarding, no extra cycle).
  - DISCARD
    - Entered from WAIT on flush_i when mem_done_i is not also high.
    - The memory transaction cannot be cancelled: mem_req_o stays high until mem_done_i.
    - On mem_done_i: the line is still filled, the result is not forwarded, go to IDLE.
    - if_stall_req_o=1 throughout, because the memory port is busy.
- flush_i in IDLE: no fetch starts that cycle; inst_valid_o=0.
- flush_i together with mem_done_i in WAIT: fill the line, no forward, go to IDLE.
- rdy=0: no state, array or output-register updates; mem_req_o and mem_addr_o held; a mem_done_i in a rdy=0 cycle must not occur (memory controller guarantees this).
- Minimum miss latency: 2 cycles (miss cycle + done cycle) when done arrives the cycle after the request.
- Back-to-back misses: the next fetch is issued no earlier than the edge after the done cycle.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined, adds two outputs:
  - hit_cnt_o (32), incremented on each rdy cycle with a hit.
  - miss_cnt_o (32), incremented on each IDLE→WAIT transition.
  - Both are cleared by rst and wrap at 2^32 to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset, then if_req_i=1, pc=32'h0000_0000 → if_stall_req_o=1 in that cycle; next cycle mem_req_o=1, mem_addr_o=0; mem_done_i with mem_inst_i=32'h0000_0513 → inst_valid_o=1, inst_o=32'h0000_0513, stall=0 in the same cycle.
- Repeat pc=0 after the fill → hit in 1 cycle, mem_req_o stays 0, inst_o=32'h0000_0513.
- Conflict: fill pc=32'h0000_0000, then fetch pc=32'h0000_0200 (same index, INDEX_BITS=7) → miss and refetch; pc=0 then misses again.
- flush_i one cycle into WAIT for pc=32'h0000_0010, done 3 cycles later → mem_req_o held until done, no inst_valid_o, line filled; later fetch of 32'h10 hits.
- rdy=0 for 4 cycles in WAIT → mem_req_o and mem_addr_o unchanged; state resumes when rdy=1.
- rst asserted in WAIT, stray mem_done_i next cycle → no fill, all lines invalid, pc=0 misses.
